microstore_wcs: RTL and testbench

- Parametrised, writable control store that replaces the fixed combinational microstore in the microprogrammed control unit.
- Microcode is streamed in through a load handshake after reset. The sequencer then fetches microinstructions through a registered microinstruction register (MIR) with hold and parity checking.
- Sits between the microsequencer (next-address logic) and the control-signal decode.

---
 rtl/microcode_pkg.sv | 17 +
 rtl/microstore_mem.sv | 43 ++++
 rtl/microstore_wcs.sv | 139 +++++++++++++
 tb/tb_microstore_wcs.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/microcode_pkg.sv
// Shared definitions for the writable control store: default widths,
// the NOP microinstruction and the load/run state encoding.
package microcode_pkg;

    localparam int unsigned WORD_W_DEF = 45;
    localparam int unsigned ADDR_W_DEF = 7;

    localparam logic [WORD_W_DEF-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        RUN  = 2'd3
    } wcs_state_e;

endpackage

// File: rtl/microstore_mem.sv
// Control-store array: one synchronous write port, one asynchronous read port.
// The even-parity bit of each word is stored above the data bits when enabled.
module microstore_mem
    import microcode_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DEPTH     = 92,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_par
);

    localparam int unsigned MEM_W = WORD_W + (PARITY_EN ? 1 : 0);

    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] rd_word;

    // Truncating cast drops the parity bit when parity is disabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= MEM_W'({^wr_data, wr_data});
        end
    end

    assign rd_word = mem[rd_addr];
    assign rd_data = rd_word[WORD_W-1:0];

    generate
        if (PARITY_EN) begin : g_par
            assign rd_par = rd_word[MEM_W-1];
        end else begin : g_nopar
            assign rd_par = ^rd_word[WORD_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/microstore_wcs.sv
// Writable control store: streamed microcode load, then registered MIR fetch
// with hold, out-of-range detection and parity checking.
module microstore_wcs
    import microcode_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DEPTH     = 92,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              hold,
    output logic [WORD_W-1:0] mir_out,
    output logic              mir_valid,
    output logic              addr_err,
    output logic              parity_err
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [WORD_W-1:0] NOP       = WORD_W'(NOP_WORD);

    wcs_state_e        state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              mem_we;
    logic [WORD_W-1:0] rd_data;
    logic              rd_par;
    logic              in_range;

    logic [WORD_W-1:0] mir_nxt;
    logic              mir_valid_nxt, addr_err_nxt, parity_err_nxt;

    microstore_mem #(
        .WORD_W   (WORD_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .PARITY_EN(PARITY_EN)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .wr_addr(ptr),
        .wr_data(ld_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_par (rd_par)
    );

    assign in_range = {1'b0, rd_addr} < DEPTH_EXT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            mir_out    <= NOP;
            mir_valid  <= 1'b0;
            addr_err   <= 1'b0;
            parity_err <= 1'b0;
            ld_ready   <= 1'b0;
            ld_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            mir_out    <= mir_nxt;
            mir_valid  <= mir_valid_nxt;
            addr_err   <= addr_err_nxt;
            parity_err <= parity_err_nxt;
            ld_ready   <= (state_nxt == LOAD);
            ld_done    <= (state_nxt == DONE);
            busy       <= (state_nxt == LOAD) || (state_nxt == DONE);
        end
    end

    // ld_start wins over everything else and always clears the MIR;
    // a word offered in the same cycle as a restart is dropped.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        mem_we         = 1'b0;
        mir_nxt        = mir_out;
        mir_valid_nxt  = mir_valid;
        addr_err_nxt   = addr_err;
        parity_err_nxt = parity_err;

        if (ld_start) begin
            state_nxt      = LOAD;
            ptr_nxt        = '0;
            mir_nxt        = NOP;
            mir_valid_nxt  = 1'b0;
            addr_err_nxt   = 1'b0;
            parity_err_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    mir_valid_nxt = 1'b0;
                end
                LOAD: begin
                    if (ld_valid) begin
                        mem_we  = 1'b1;
                        ptr_nxt = ptr + ADDR_W'(1);
                        if (ptr == LAST_PTR) begin
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    state_nxt = RUN;
                end
                RUN: begin
                    if (rd_en && !hold) begin
                        mir_valid_nxt = 1'b1;
                        if (in_range) begin
                            mir_nxt        = rd_data;
                            addr_err_nxt   = 1'b0;
                            parity_err_nxt = PARITY_EN && ((^rd_data) != rd_par);
                        end else begin
                            mir_nxt        = NOP;
                            addr_err_nxt   = 1'b1;
                            parity_err_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microstore_wcs.sv
// Scoreboarded bench for the writable control store: a queue of expected
// per-cycle outputs from a behavioural model, popped by an independent monitor.
module tb_microstore_wcs;

    localparam int WW    = 45;
    localparam int AW    = 7;
    localparam int DEPTH = 92;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_RUN  = 3;

    typedef struct packed {
        logic [WW-1:0] mir;
        logic          valid;
        logic          aerr;
        logic          perr;
        logic          rdy;
        logic          done;
        logic          busy;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_start = 1'b0, ld_valid = 1'b0;
    logic [WW-1:0] ld_data = '0;
    logic          ld_ready, ld_done, busy;
    logic          rd_en = 1'b0, hold = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [WW-1:0] mir_out;
    logic          mir_valid, addr_err, parity_err;

    int checks = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Behavioural model
    int            m_mode;
    int            m_ptr;
    logic [WW-1:0] m_mem [128];
    bit            m_bad [128];
    exp_t          m_out;

    microstore_wcs #(
        .WORD_W(WW), .ADDR_W(AW), .DEPTH(DEPTH), .PARITY_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .hold(hold),
        .mir_out(mir_out), .mir_valid(mir_valid),
        .addr_err(addr_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t sample();
        exp_t s;
        s.mir   = mir_out;
        s.valid = mir_valid;
        s.aerr  = addr_err;
        s.perr  = parity_err;
        s.rdy   = ld_ready;
        s.done  = ld_done;
        s.busy  = busy;
        return s;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got mir=%h v=%b ae=%b pe=%b rdy=%b done=%b busy=%b want mir=%h v=%b ae=%b pe=%b rdy=%b done=%b busy=%b",
                     name, $time, act.mir, act.valid, act.aerr, act.perr, act.rdy, act.done, act.busy,
                     exp.mir, exp.valid, exp.aerr, exp.perr, exp.rdy, exp.done, exp.busy);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_ptr  = 0;
        m_out  = '0;
    endfunction

    function automatic void model_step(input bit ls, input bit lv, input logic [WW-1:0] ld,
                                       input bit re, input int ra, input bit h);
        if (ls) begin
            m_mode = M_LOAD;
            m_ptr  = 0;
            m_out.mir = '0; m_out.valid = 0; m_out.aerr = 0; m_out.perr = 0;
        end else if (m_mode == M_LOAD) begin
            if (lv) begin
                m_mem[m_ptr] = ld;
                m_bad[m_ptr] = 0;
                m_ptr++;
                if (m_ptr == DEPTH) m_mode = M_DONE;
            end
        end else if (m_mode == M_DONE) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN && re && !h) begin
            m_out.valid = 1;
            if (ra < DEPTH) begin
                m_out.mir  = m_mem[ra];
                m_out.aerr = 0;
                m_out.perr = m_bad[ra];
            end else begin
                m_out.mir  = '0;
                m_out.aerr = 1;
                m_out.perr = 0;
            end
        end
        m_out.rdy  = (m_mode == M_LOAD);
        m_out.done = (m_mode == M_DONE);
        m_out.busy = (m_mode == M_LOAD) || (m_mode == M_DONE);
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the next edge
    task automatic step(input bit ls, input bit lv, input logic [WW-1:0] ld,
                        input bit re, input int ra, input bit h);
        @(negedge clk);
        ld_start = ls; ld_valid = lv; ld_data = ld;
        rd_en = re; rd_addr = AW'(ra); hold = h;
        model_step(ls, lv, ld, re, ra, h);
        exp_q.push_back(m_out);
    endtask

    task automatic idle_cycle();
        step(0, 0, '0, 0, 0, 0);
    endtask

    task automatic fetch(input int a);
        step(0, 0, '0, 1, a, 0);
    endtask

    function automatic logic [WW-1:0] rnd_word();
        logic [WW-1:0] w;
        w = {13'($urandom), 32'($urandom)};
        return w;
    endfunction

    // Monitor: pops one expectation per clock edge while stimulus is queued
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                check("cycle", sample(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [WW:0]   bd;
        logic [WW-1:0] w;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", sample(), exp_t'(0));
        @(negedge clk);
        reset = 1'b0;

        // Reads in IDLE are ignored
        fetch(3);
        fetch(0);

        // Partial load interrupted by an asynchronous reset
        step(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, rnd_word(), 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("reset_midload", sample(), exp_t'(0));
        exp_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        fetch(5);

        // Full load, ld_valid every other cycle
        step(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, rnd_word(), 0, 0, 0);
            w = WW'(i) * 45'h1F3;
            step(0, 1, w, 0, 0, 0);
        end
        idle_cycle();
        idle_cycle();

        fetch(0);
        fetch(1);
        fetch(91);

        // Hold beats rd_en
        fetch(2);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 5, 1);
        fetch(5);
        step(0, 0, '0, 0, 9, 0);

        // Out-of-range fetch then recovery
        fetch(100);
        fetch(127);
        step(0, 0, '0, 1, 3, 1);
        fetch(3);
        fetch(DEPTH);

        // Backdoor parity fault on word 7
        @(negedge clk);
        exp_q.push_back(m_out);
        bd = dut.u_mem.mem[7];
        bd[0] = ~bd[0];
        dut.u_mem.mem[7] = bd;
        m_mem[7][0] = ~m_mem[7][0];
        m_bad[7] = 1;
        fetch(7);
        fetch(8);
        fetch(7);

        // Random fetch traffic
        for (int i = 0; i < 200; i++) begin
            step(0, 0, '0, bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 127)),
                 bit'($urandom_range(0, 3) == 0));
        end

        // Reload requested alongside a fetch
        step(1, 0, '0, 1, 4, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 4, 0);
        for (int i = 0; i < 400 && m_mode == M_LOAD; i++) begin
            step(0, bit'($urandom_range(0, 1)), rnd_word(), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 127)), 0);
        end
        idle_cycle();
        for (int i = 0; i < 150; i++) begin
            step(0, 0, '0, bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 127)),
                 bit'($urandom_range(0, 4) == 0));
        end
        idle_cycle();

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d left want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
